// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS controller: IF/ID/EX/MEM/WB sequencing with wait-state timeout and traps.
// Optional branch support (beq/bne) is enabled by defining CTRL_BRANCH_EN.
module mc_ctrl_unit #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned IMM_W       = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst,
  input  logic              mem_ready,
  input  logic              zero,
  output logic [2:0]        state,
  output logic              mem_req,
  output logic              Mem_Write,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_src,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd,
  output logic [IMM_W-1:0]  imm,
  output logic              imm_s,
  output logic              rt_imm_s,
  output logic              rd_rt_s,
  output logic              alu_mem_s,
  output logic [2:0]        ALU_OP,
  output logic              Write_Reg,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StTrap = 3'd7
  } state_e;

  localparam logic [7:0] WaitLimit = 8'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic [7:0]         wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;

  logic [5:0] op, funct;
  logic [4:0] shamt;
  logic       dec_legal, dec_nop, dec_lw, dec_sw, dec_br, dec_bne;
  logic       dec_imm_s, dec_rt_imm_s, dec_rd_rt_s;
  logic [2:0] dec_alu_op;
  logic       timeout;

  logic mem_req_c, mem_write_c, ir_write_c, pc_write_c, pc_src_c, write_reg_c;

  assign op    = ir_q[31:26];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];

  // Decode from the registered IR so fields hold steady from ID until the next fetch.
  always_comb begin
    dec_legal    = 1'b0;
    dec_nop      = 1'b0;
    dec_lw       = 1'b0;
    dec_sw       = 1'b0;
    dec_br       = 1'b0;
    dec_bne      = 1'b0;
    dec_imm_s    = 1'b0;
    dec_rt_imm_s = 1'b0;
    dec_rd_rt_s  = 1'b0;
    dec_alu_op   = 3'b000;
    case (op)
      6'b000000: begin
        if (shamt == 5'd0) begin
          dec_legal = 1'b1;
          case (funct)
            6'b100000: dec_alu_op = 3'b100;
            6'b100010: dec_alu_op = 3'b101;
            6'b100100: dec_alu_op = 3'b000;
            6'b100101: dec_alu_op = 3'b001;
            6'b100110: dec_alu_op = 3'b010;
            6'b100111: dec_alu_op = 3'b011;
            6'b101011: dec_alu_op = 3'b110;
            6'b000100: dec_alu_op = 3'b111;
            6'b000000: dec_nop    = 1'b1;
            default:   dec_legal  = 1'b0;
          endcase
        end
      end
      6'b001000: begin
        dec_legal = 1'b1; dec_imm_s = 1'b1; dec_alu_op = 3'b100;
        dec_rt_imm_s = 1'b1; dec_rd_rt_s = 1'b1;
      end
      6'b001100: begin
        dec_legal = 1'b1; dec_alu_op = 3'b000; dec_rt_imm_s = 1'b1; dec_rd_rt_s = 1'b1;
      end
      6'b001110: begin
        dec_legal = 1'b1; dec_alu_op = 3'b010; dec_rt_imm_s = 1'b1; dec_rd_rt_s = 1'b1;
      end
      6'b001011: begin
        dec_legal = 1'b1; dec_alu_op = 3'b110; dec_rt_imm_s = 1'b1; dec_rd_rt_s = 1'b1;
      end
      6'b100011: begin
        dec_legal = 1'b1; dec_lw = 1'b1; dec_imm_s = 1'b1; dec_alu_op = 3'b100;
        dec_rt_imm_s = 1'b1; dec_rd_rt_s = 1'b1;
      end
      6'b101011: begin
        dec_legal = 1'b1; dec_sw = 1'b1; dec_imm_s = 1'b1; dec_alu_op = 3'b100;
        dec_rt_imm_s = 1'b1; dec_rd_rt_s = 1'b1;
      end
`ifdef CTRL_BRANCH_EN
      6'b000100, 6'b000101: begin
        dec_legal = 1'b1; dec_br = 1'b1; dec_bne = op[0];
        dec_imm_s = 1'b1; dec_alu_op = 3'b101;
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  assign timeout = (wait_q == WaitLimit);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    wait_d      = 8'd0;
    retired_d   = retired_q;
    trap_d      = trap_q;
    cause_d     = cause_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 1'b0;
    write_reg_c = 1'b0;
    case (state_q)
      StIf: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          ir_d       = inst;
          state_d    = StId;
        end else if (timeout) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StId: begin
        if (dec_legal) begin
          state_d = StEx;
        end else begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end
      end
      StEx: begin
        if (dec_nop || dec_br) begin
          // Taken when beq sees zero=1 or bne sees zero=0.
          if (dec_br && (zero ^ dec_bne)) begin
            pc_write_c = 1'b1;
            pc_src_c   = 1'b1;
          end
          retired_d = retired_q + CNT_W'(1);
          state_d   = StIf;
        end else if (dec_lw || dec_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_req_c   = 1'b1;
        mem_write_c = dec_sw;
        if (mem_ready) begin
          if (dec_sw) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = StIf;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWb: begin
        write_reg_c = 1'b1;
        retired_d   = retired_q + CNT_W'(1);
        state_d     = StIf;
      end
      StTrap: state_d = StTrap;
      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIf;
      ir_q      <= 32'd0;
      wait_q    <= 8'd0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  // Strobes are forced low while reset is held.
  assign mem_req   = mem_req_c   & ~rst;
  assign Mem_Write = mem_write_c & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign pc_write  = pc_write_c  & ~rst;
  assign Write_Reg = write_reg_c & ~rst;
`ifdef CTRL_BRANCH_EN
  assign pc_src    = pc_src_c    & ~rst;
`else
  logic unused_branch;
  assign unused_branch = zero ^ pc_src_c;
  assign pc_src        = 1'b0;
`endif

  assign state      = state_q;
  assign rs         = ir_q[21 +: REG_AW];
  assign rt         = ir_q[16 +: REG_AW];
  assign rd         = ir_q[11 +: REG_AW];
  assign imm        = ir_q[IMM_W-1:0];
  assign imm_s      = dec_imm_s;
  assign rt_imm_s   = dec_rt_imm_s;
  assign rd_rt_s    = dec_rd_rt_s;
  assign alu_mem_s  = dec_lw;
  assign ALU_OP     = dec_alu_op;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule
